// File: rtl/wb_write_buffer_pkg.sv
// Shared types for the write-back buffer and the register-bank write side.
package wb_write_buffer_pkg;

    localparam int REG_IDX_W = 4;
    localparam int DATA_W    = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] addr;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over pending entries for one register read port.
// Entry 0 is the oldest (head), entry DEPTH-1 the youngest possible.
module wb_fwd_match
    import wb_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      entry_valid,
    input  logic [REG_IDX_W-1:0]  rd_addr,
    output logic                  hit,
    output logic [DATA_W-1:0]     fwd
);

    // Later (younger) matches overwrite earlier ones, so the youngest wins.
    always_comb begin
        hit = 1'b0;
        fwd = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entries[i].addr == rd_addr)) begin
                hit = 1'b1;
                fwd = entries[i].data;
            end else begin
                hit = hit;
                fwd = fwd;
            end
        end
    end

endmodule

// File: rtl/wb_write_buffer.sv
// Register write-back FIFO with in-order retirement and read-port forwarding
// of pending data.
module wb_write_buffer
    import wb_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_IDX_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   wr_stall,
    output logic                   wr_en,
    output logic [REG_IDX_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    input  logic [REG_IDX_W-1:0]   rs_addr,
    output logic                   rs_hit,
    output logic [DATA_W-1:0]      rs_fwd,
    input  logic [REG_IDX_W-1:0]   rt_addr,
    output logic                   rt_hit,
    output logic [DATA_W-1:0]      rt_fwd,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    wb_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic                  push;
    logic                  pop;
    wb_entry_t [DEPTH-1:0] age_entries;
    logic [DEPTH-1:0]      age_valid;

    // Handshake, retire port and head presentation.
    always_comb begin
        in_ready = !reset && (count_q != FULL_CNT);
        wr_en    = (count_q != {CNT_W{1'b0}}) && !wr_stall;
        push     = in_valid && in_ready;
        pop      = wr_en;
        count    = count_q;
        if (count_q != {CNT_W{1'b0}}) begin
            wr_addr = mem_q[head_q].addr;
            wr_data = mem_q[head_q].data;
        end else begin
            wr_addr = {REG_IDX_W{1'b0}};
            wr_data = {DATA_W{1'b0}};
        end
    end

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (push) begin
            mem_d[tail_q] = '{addr: in_addr, data: in_data};
            tail_d        = tail_q + PTR_W'(1'b1);
        end else begin
            tail_d = tail_q;
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1'b1);
        end else begin
            head_d = head_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1'b1);
            2'b01:   count_d = count_q - CNT_W'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards queued entries by clearing the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Present occupied entries oldest-first; forwarding is silenced in reset.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            age_entries[i] = mem_q[head_q + PTR_W'(i)];
            age_valid[i]   = !reset && (CNT_W'(i) < count_q);
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
        .entries     (age_entries),
        .entry_valid (age_valid),
        .rd_addr     (rs_addr),
        .hit         (rs_hit),
        .fwd         (rs_fwd)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
        .entries     (age_entries),
        .entry_valid (age_valid),
        .rd_addr     (rt_addr),
        .hit         (rt_hit),
        .fwd         (rt_fwd)
    );

endmodule
